// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time instruction loader. It takes a length-prefixed byte stream over a
// valid/ready handshake and writes the bytes into instruction memory from
// address 0. The unused tail is zero-filled. The core is held in reset until
// the whole memory has been written. A malformed image parks the loader in a
// terminal error state. The core stays in reset and a sticky error flag is set.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to expect a trailing
// checksum byte. It is the mod-256 sum of the instruction bytes, and a
// mismatch rejects the image.
//
// Parameters:
//   DEPTH   instruction memory depth in 8-bit words (power of two, 2..256)
//   ADDR_W  address width, log2(DEPTH)
//
// Ports:
//   Clk          clock, rising edge
//   Reset        asynchronous active-high reset
//   In_Valid     In_Data carries a byte
//   In_Data      image byte (length, instructions, optional checksum)
//   In_Ready     loader accepts a byte this cycle (decoded from state)
//   Mem_Wr_En    instruction memory write strobe (registered)
//   Mem_Wr_Addr  write address (registered)
//   Mem_Wr_Data  write data (registered)
//   Core_Reset   reset to the core, high until the load completes
//   Load_Done    image loaded, core released (sticky)
//   Load_Error   image rejected (sticky)
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              In_Valid,
    input  logic [7:0]        In_Data,
    output logic              In_Ready,
    output logic              Mem_Wr_En,
    output logic [ADDR_W-1:0] Mem_Wr_Addr,
    output logic [7:0]        Mem_Wr_Data,
    output logic              Core_Reset,
    output logic              Load_Done,
    output logic              Load_Error
);

    typedef enum logic [2:0] {
        S_WAIT_LEN = 3'd0,
        S_LOAD     = 3'd1,
        S_CHECK    = 3'd2,
        S_FILL     = 3'd3,
        S_DONE     = 3'd4,
        S_ERROR    = 3'd5
    } state_t;

    // The length byte is compared in 9 bits so that DEPTH=256 is representable.
    localparam logic [8:0]      DEPTH_9 = 9'(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_A  = (ADDR_W+1)'(DEPTH - 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction
`endif

    state_t            state_r;
    logic [ADDR_W:0]   len_r;
    // One bit wider than the address so that N==DEPTH terminates without wrapping.
    logic [ADDR_W:0]   addr_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_r;
`endif
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [7:0]        wr_data_r;
    logic              core_reset_r;
    logic              done_r;
    logic              error_r;

    logic              in_ready_s;
    logic              accept_s;
    logic [8:0]        len_in_s;
    logic              len_ok_s;
    logic [ADDR_W:0]   addr_next_s;
    logic              last_byte_s;
    logic              full_s;

    // Handshake readiness and length/address qualifiers.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            S_WAIT_LEN: in_ready_s = 1'b1;
            S_LOAD:     in_ready_s = 1'b1;
            S_CHECK:    in_ready_s = 1'b1;
            default:    in_ready_s = 1'b0;
        endcase
        accept_s    = In_Valid && in_ready_s;
        len_in_s    = {1'b0, In_Data};
        len_ok_s    = (In_Data != 8'h00) && (len_in_s <= DEPTH_9);
        addr_next_s = addr_r + {{ADDR_W{1'b0}}, 1'b1};
        last_byte_s = (addr_next_s == len_r);
        full_s      = (len_r == DEPTH_A);
    end

    // Loader FSM with registered memory-write and status outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r      <= S_WAIT_LEN;
            len_r        <= {(ADDR_W+1){1'b0}};
            addr_r       <= {(ADDR_W+1){1'b0}};
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r       <= 8'h00;
`endif
            wr_en_r      <= 1'b0;
            wr_addr_r    <= {ADDR_W{1'b0}};
            wr_data_r    <= 8'h00;
            core_reset_r <= 1'b1;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            // The write strobe is a one-cycle pulse per written word.
            wr_en_r <= 1'b0;
            case (state_r)
                S_WAIT_LEN: begin
                    if (accept_s) begin
                        if (len_ok_s) begin
                            len_r   <= len_in_s[ADDR_W:0];
                            addr_r  <= {(ADDR_W+1){1'b0}};
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum_r  <= 8'h00;
`endif
                            state_r <= S_LOAD;
                        end else begin
                            error_r <= 1'b1;
                            state_r <= S_ERROR;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept_s) begin
                        wr_en_r   <= 1'b1;
                        wr_addr_r <= addr_r[ADDR_W-1:0];
                        wr_data_r <= In_Data;
                        addr_r    <= addr_next_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_r    <= csum_add(csum_r, In_Data);
                        if (last_byte_s) begin
                            state_r <= S_CHECK;
                        end
`else
                        if (last_byte_s) begin
                            state_r <= full_s ? S_DONE : S_FILL;
                        end
`endif
                    end
                end
                S_CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (accept_s) begin
                        if (In_Data == csum_r) begin
                            state_r <= full_s ? S_DONE : S_FILL;
                        end else begin
                            error_r <= 1'b1;
                            state_r <= S_ERROR;
                        end
                    end
`else
                    // Unreachable without the checksum trailer; treat as a fault.
                    error_r <= 1'b1;
                    state_r <= S_ERROR;
`endif
                end
                S_FILL: begin
                    // On entry addr_r holds N, the first unused word.
                    wr_en_r   <= 1'b1;
                    wr_addr_r <= addr_r[ADDR_W-1:0];
                    wr_data_r <= 8'h00;
                    addr_r    <= addr_next_s;
                    if (addr_r == LAST_A) begin
                        state_r <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Reached one edge after the final strobe began, so memory is complete here.
                    core_reset_r <= 1'b0;
                    done_r       <= 1'b1;
                end
                S_ERROR: begin
                    core_reset_r <= 1'b1;
                    error_r      <= 1'b1;
                end
                default: begin
                    core_reset_r <= 1'b1;
                    error_r      <= 1'b1;
                    state_r      <= S_ERROR;
                end
            endcase
        end
    end

    assign In_Ready    = in_ready_s;
    assign Mem_Wr_En   = wr_en_r;
    assign Mem_Wr_Addr = wr_addr_r;
    assign Mem_Wr_Data = wr_data_r;
    assign Core_Reset  = core_reset_r;
    assign Load_Done   = done_r;
    assign Load_Error  = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Scoreboard bench for imem_loader (DEPTH=32). The stimulus tasks push the
// expected memory writes into a queue. A monitor pops from the queue and
// compares on every write strobe, sampling on the falling edge. Status flags
// are checked directly from the stimulus thread. The bench works with and
// without IMEM_LOADER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              Clk      = 1'b0;
    logic              Reset    = 1'b1;
    logic              In_Valid = 1'b0;
    logic [7:0]        In_Data  = 8'h00;
    logic              In_Ready;
    logic              Mem_Wr_En;
    logic [ADDR_W-1:0] Mem_Wr_Addr;
    logic [7:0]        Mem_Wr_Data;
    logic              Core_Reset;
    logic              Load_Done;
    logic              Load_Error;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  tests       = 0;
    int  fails       = 0;
    int  cyc         = 0;
    int  last_wr_cyc = 0;
    int  wr_cyc[DEPTH];

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .In_Valid    (In_Valid),
        .In_Data     (In_Data),
        .In_Ready    (In_Ready),
        .Mem_Wr_En   (Mem_Wr_En),
        .Mem_Wr_Addr (Mem_Wr_Addr),
        .Mem_Wr_Data (Mem_Wr_Data),
        .Core_Reset  (Core_Reset),
        .Load_Done   (Load_Done),
        .Load_Error  (Load_Error)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input int a, input logic [7:0] d);
        wr_t e;
        e.addr = 8'(a);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_fill(input int from);
        for (int a = from; a < DEPTH; a++) push_wr(a, 8'h00);
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    initial begin
        wr_t e;
        forever begin
            @(negedge Clk);
            if (Mem_Wr_En === 1'b1) begin
                last_wr_cyc = cyc;
                wr_cyc[Mem_Wr_Addr] = cyc;
                chk("core_reset_during_write", {31'd0, Core_Reset}, 32'd1);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: addr %0d data %02h, no write expected", Mem_Wr_Addr, Mem_Wr_Data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", {27'd0, Mem_Wr_Addr}, {24'd0, e.addr});
                    chk("wr_data", {24'd0, Mem_Wr_Data}, {24'd0, e.data});
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge Clk);
        Reset    = 1'b1;
        In_Valid = 1'b0;
        In_Data  = 8'h00;
        #1;
        chk("rst_in_ready",   {31'd0, In_Ready},   32'd1);
        chk("rst_wr_en",      {31'd0, Mem_Wr_En},  32'd0);
        chk("rst_core_reset", {31'd0, Core_Reset}, 32'd1);
        chk("rst_done",       {31'd0, Load_Done},  32'd0);
        chk("rst_error",      {31'd0, Load_Error}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Present one byte from the falling edge and return just after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge Clk);
        In_Valid = 1'b1;
        In_Data  = b;
        n = 0;
        while (In_Ready !== 1'b1 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (In_Ready !== 1'b1) begin
            chk("ready_timeout", {31'd0, In_Ready}, 32'd1);
        end else begin
            @(posedge Clk);
        end
    endtask

    task automatic idle(input int n);
        @(negedge Clk);
        In_Valid = 1'b0;
        repeat (n) @(negedge Clk);
    endtask

    // exp_lat < 0 skips the release-latency check.
    task automatic wait_done(input int exp_lat);
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            if (Load_Done === 1'b1) break;
        end
        chk("load_done", {31'd0, Load_Done}, 32'd1);
        if (exp_lat >= 0) chk("release_latency", 32'(cyc - last_wr_cyc), 32'(exp_lat));
        chk("core_released", {31'd0, Core_Reset}, 32'd0);
        chk("no_error", {31'd0, Load_Error}, 32'd0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] bad_len[2];
        logic [7:0] d;
        logic [7:0] sum;
        int         gap;

        // 1: short image, continuous stream, then zero fill
        do_reset();
        push_wr(0, 8'h41);
        push_wr(1, 8'h8A);
        push_wr(2, 8'hC1);
        push_fill(3);
        send_byte(8'h03);
        send_byte(8'h41);
        send_byte(8'h8A);
        send_byte(8'hC1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h8C);
`endif
        idle(0);
        wait_done(1);
        chk("load_back_to_back", 32'(wr_cyc[2] - wr_cyc[0]), 32'd2);
        chk("fill_back_to_back", 32'(wr_cyc[31] - wr_cyc[3]), 32'd28);

        // 6: after DONE, further input is refused
        @(negedge Clk);
        In_Valid = 1'b1;
        In_Data  = 8'h55;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            chk("done_in_ready", {31'd0, In_Ready}, 32'd0);
            chk("done_sticky",   {31'd0, Load_Done}, 32'd1);
        end
        idle(2);
        chk("done_no_writes", 32'(exp_q.size()), 32'd0);

        // 2: illegal lengths 0 and 33
        bad_len[0] = 8'h00;
        bad_len[1] = 8'h21;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            send_byte(bad_len[k]);
            #1;
            chk("badlen_error", {31'd0, Load_Error}, 32'd1);
            chk("badlen_ready", {31'd0, In_Ready},   32'd0);
            chk("badlen_core",  {31'd0, Core_Reset}, 32'd1);
            idle(5);
            chk("badlen_sticky", {31'd0, Load_Error}, 32'd1);
            chk("badlen_done",   {31'd0, Load_Done},  32'd0);
        end

        // 3: full-depth image with random stalls, no fill
        do_reset();
        sum = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'(i * 37 + 5);
            push_wr(i, d);
            sum = sum + d;
        end
        send_byte(8'h20);
        for (int i = 0; i < DEPTH; i++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) idle(gap - 1);
            d = 8'(i * 37 + 5);
            send_byte(d);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(sum);
        idle(0);
        wait_done(-1);
`else
        idle(0);
        wait_done(1);
`endif

`ifdef IMEM_LOADER_CHECKSUM_EN
        // 4: checksum pass and checksum mismatch
        do_reset();
        push_wr(0, 8'h10);
        push_wr(1, 8'h20);
        push_fill(2);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h30);
        idle(0);
        wait_done(1);

        do_reset();
        push_wr(0, 8'h10);
        push_wr(1, 8'h20);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h31);
        #1;
        chk("csum_error", {31'd0, Load_Error}, 32'd1);
        idle(40);
        chk("csum_no_fill", 32'(exp_q.size()), 32'd0);
        chk("csum_core",    {31'd0, Core_Reset}, 32'd1);
        chk("csum_done",    {31'd0, Load_Done},  32'd0);
`endif

        // 5: reset mid-load, then a fresh image
        do_reset();
        push_wr(0, 8'h11);
        push_wr(1, 8'h22);
        send_byte(8'h05);
        send_byte(8'h11);
        send_byte(8'h22);
        idle(0);
        @(posedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        chk("midrst_wr_en",   {31'd0, Mem_Wr_En},   32'd0);
        chk("midrst_addr",    {27'd0, Mem_Wr_Addr}, 32'd0);
        chk("midrst_data",    {24'd0, Mem_Wr_Data}, 32'd0);
        chk("midrst_core",    {31'd0, Core_Reset},  32'd1);
        chk("midrst_ready",   {31'd0, In_Ready},    32'd1);
        chk("midrst_drained", 32'(exp_q.size()),    32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        push_wr(0, 8'h7F);
        push_fill(1);
        send_byte(8'h01);
        send_byte(8'h7F);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h7F);
`endif
        idle(0);
        wait_done(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
